// File: rtl/boton_antirrebote_if.sv
`default_nettype none
// ============================================================================
// Module      : boton_antirrebote_if
// Description : Signal bundle between a raw push-button source and the
//               debouncer. The slave modport is the debouncer's view. The
//               master modport is the view of whatever drives the button and
//               consumes the clean outputs.
//   btn_i      raw button level, asynchronous to the system clock
//   btn_o      debounced level, 1 = pressed
//   press_o    one-cycle strobe when btn_o goes 0->1
//   release_o  one-cycle strobe when btn_o goes 1->0
//   busy_o     1 while a candidate level is being qualified
// Revision    : 1.0 - initial release
// ============================================================================
interface boton_antirrebote_if;
    logic btn_i;
    logic btn_o;
    logic press_o;
    logic release_o;
    logic busy_o;

    modport slave (
        input  btn_i,
        output btn_o,
        output press_o,
        output release_o,
        output busy_o
    );

    modport master (
        output btn_i,
        input  btn_o,
        input  press_o,
        input  release_o,
        input  busy_o
    );
endinterface : boton_antirrebote_if
`default_nettype wire

// File: rtl/boton_antirrebote.sv
`default_nettype none
// ============================================================================
// Module      : boton_antirrebote
// Description : Push-button debouncer. It has a 2-FF synchronizer, a
//               stability counter and a 4-state qualification FSM. The
//               debounced level changes only after STABLE_CYCLES consecutive
//               synchronized samples at the new level. One-cycle press and
//               release strobes come with each accepted change.
// Ports       :
//   clk      in   system clock, rising edge
//   rst_i    in   asynchronous active-high reset
//   bus      slave modport of boton_antirrebote_if. It carries btn_i in, and
//            btn_o, press_o, release_o and busy_o out. All outputs are
//            registered.
// Revision    : 1.0 - initial release
// ============================================================================
module boton_antirrebote #(
    parameter int STABLE_CYCLES = 500000,  // legal >= 2
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  wire logic            clk,
    input  wire logic            rst_i,
    boton_antirrebote_if.slave   bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // Polarity is normalised before synchronisation, so the chain always
    // carries "pressed = 1".
    logic w_raw;
    logic w_s;
    logic sync1_q;
    logic sync2_q;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             btn_q,     btn_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;
    logic             busy_q,    busy_d;

    assign w_raw = ACTIVE_LOW ? ~bus.btn_i : bus.btn_i;
    assign w_s   = sync2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        btn_d     = btn_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (w_s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!w_s) begin
                    // A bounce abandons the candidate. The next high sample
                    // starts again from cnt=1.
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    btn_d   = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!w_s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (w_s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d   = IDLE_LOW;
                    cnt_d     = '0;
                    btn_d     = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
                btn_d   = 1'b0;
            end
        endcase
        // busy_o is registered, so it is derived from the next state. That
        // makes it track the state register exactly.
        busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync1_q   <= w_raw;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.btn_o     = btn_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;
    assign bus.busy_o    = busy_q;

endmodule : boton_antirrebote
`default_nettype wire

// File: tb/tb_boton_antirrebote.sv
`default_nettype none
// ============================================================================
// Module      : tb_boton_antirrebote
// Description : Directed self-checking bench for boton_antirrebote with
//               STABLE_CYCLES=4 and ACTIVE_LOW=1. Stimulus changes #1 after a
//               rising edge, so the following edge is the capture edge E0.
//               Outputs are observed #1 after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boton_antirrebote;

    logic clk;
    logic rst_i;
    boton_antirrebote_if bus ();

    boton_antirrebote #(
        .STABLE_CYCLES (4),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Strobe tallies, and a model of the downstream edge counter. That
    // counter counts rising edges of its enable, which is driven by btn_o.
    int   press_total   = 0;
    int   release_total = 0;
    int   edge_total    = 0;
    logic btn_prev      = 1'b0;
    logic both_seen     = 1'b0;

    always @(negedge clk) begin
        if (bus.press_o === 1'b1)   press_total++;
        if (bus.release_o === 1'b1) release_total++;
        if (bus.btn_o === 1'b1 && btn_prev !== 1'b1) edge_total++;
        if (bus.press_o === 1'b1 && bus.release_o === 1'b1) both_seen = 1'b1;
        btn_prev = bus.btn_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_i      = 1'b1;
        bus.btn_i  = 1'b1;               // released (active low)
        tick(3);
        vectors++;
        if ({bus.btn_o, bus.press_o, bus.release_o, bus.busy_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected 0000",
                     {bus.btn_o, bus.press_o, bus.release_o, bus.busy_o});
        end
        rst_i = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick(1);
            vectors++;
            if ({bus.btn_o, bus.press_o, bus.release_o, bus.busy_o} !== 4'b0000) begin
                miscompares++;
                $display("FAIL idle_released cyc=%0d: got %b expected 0000", k,
                         {bus.btn_o, bus.press_o, bus.release_o, bus.busy_o});
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_press();
        logic [3:0] exp;
        bus.btn_i = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            tick(1);                     // now just after E0+k
            exp = {(k >= 5), (k == 5), 1'b0, (k >= 2 && k <= 4)};
            vectors++;
            if ({bus.btn_o, bus.press_o, bus.release_o, bus.busy_o} !== exp) begin
                miscompares++;
                $display("FAIL press E0+%0d {btn,press,rel,busy}: got %b expected %b", k,
                         {bus.btn_o, bus.press_o, bus.release_o, bus.busy_o}, exp);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_release();
        logic [3:0] exp;
        bus.btn_i = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick(1);
            exp = {(k < 5), 1'b0, (k == 5), (k >= 2 && k <= 4)};
            vectors++;
            if ({bus.btn_o, bus.press_o, bus.release_o, bus.busy_o} !== exp) begin
                miscompares++;
                $display("FAIL release E0+%0d {btn,press,rel,busy}: got %b expected %b", k,
                         {bus.btn_o, bus.press_o, bus.release_o, bus.busy_o}, exp);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Low for 3 clocks, high for 1, then low. The candidate reaches cnt=3
    // and is then rejected. The final capture is at E0+4, so the press
    // lands at E0+9.
    task automatic test_bounce_press();
        logic [3:0] exp;
        int p0;
        p0 = press_total;
        for (int k = 0; k <= 10; k++) begin
            if (k == 0) bus.btn_i = 1'b0;
            if (k == 3) bus.btn_i = 1'b1;
            if (k == 4) bus.btn_i = 1'b0;
            tick(1);
            exp = {(k >= 9), (k == 9), 1'b0,
                   ((k >= 2 && k <= 4) || (k >= 6 && k <= 8))};
            vectors++;
            if ({bus.btn_o, bus.press_o, bus.release_o, bus.busy_o} !== exp) begin
                miscompares++;
                $display("FAIL bounce E0+%0d {btn,press,rel,busy}: got %b expected %b", k,
                         {bus.btn_o, bus.press_o, bus.release_o, bus.busy_o}, exp);
            end
        end
        tick(2);
        vectors++;
        if (press_total - p0 !== 1) begin
            miscompares++;
            $display("FAIL bounce_press_count: got %0d expected 1", press_total - p0);
        end
        bus.btn_i = 1'b1;                // back to released
        tick(10);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_qualify();
        logic [3:0] exp;
        int p0;
        bus.btn_i = 1'b0;
        tick(4);                         // after E0+3: WAIT_HIGH, cnt=2
        vectors++;
        if (bus.busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy_before_reset: got %b expected 1", bus.busy_o);
        end
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({bus.btn_o, bus.press_o, bus.release_o, bus.busy_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %b expected 0000",
                     {bus.btn_o, bus.press_o, bus.release_o, bus.busy_o});
        end
        tick(2);
        p0    = press_total;
        rst_i = 1'b0;                    // next edge is the first post-reset edge R0
        for (int k = 0; k <= 7; k++) begin
            tick(1);
            exp = {(k >= 5), (k == 5), 1'b0, (k >= 2 && k <= 4)};
            vectors++;
            if ({bus.btn_o, bus.press_o, bus.release_o, bus.busy_o} !== exp) begin
                miscompares++;
                $display("FAIL post_reset R0+%0d {btn,press,rel,busy}: got %b expected %b", k,
                         {bus.btn_o, bus.press_o, bus.release_o, bus.busy_o}, exp);
            end
        end
        vectors++;
        if (press_total - p0 !== 1) begin
            miscompares++;
            $display("FAIL post_reset_press_count: got %0d expected 1", press_total - p0);
        end
    endtask

    // ------------------------------------------------------------------
    // Reset arrives while btn_o is high. btn_o must drop asynchronously with
    // no release strobe, and a fresh press must then be qualified.
    task automatic test_reset_while_pressed();
        int r0;
        r0 = release_total;
        @(posedge clk);
        #3;
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({bus.btn_o, bus.release_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_pressed_async {btn,rel}: got %b expected 00",
                     {bus.btn_o, bus.release_o});
        end
        tick(1);
        rst_i = 1'b0;
        tick(8);
        vectors++;
        if (bus.btn_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pressed_requalify: got %b expected 1", bus.btn_o);
        end
        vectors++;
        if (release_total - r0 !== 0) begin
            miscompares++;
            $display("FAIL reset_pressed_no_release: got %0d expected 0", release_total - r0);
        end
        bus.btn_i = 1'b1;
        tick(10);
    endtask

    // ------------------------------------------------------------------
    task automatic bouncy_level(input logic level, input int bounces);
        for (int i = 0; i < bounces; i++) begin
            bus.btn_i = level;
            tick(2);                     // 2 samples < 4: always rejected
            bus.btn_i = ~level;
            tick(1);
        end
        bus.btn_i = level;
        tick(12);
    endtask

    task automatic test_back_to_back_downstream();
        int p0, r0, e0;
        int nb [3] = '{0, 2, 3};
        p0 = press_total;
        r0 = release_total;
        e0 = edge_total;
        both_seen = 1'b0;
        for (int p = 0; p < 3; p++) begin
            bouncy_level(1'b0, nb[p]);   // press
            bouncy_level(1'b1, nb[p]);   // release
        end
        vectors++;
        if (edge_total - e0 !== 3) begin
            miscompares++;
            $display("FAIL downstream_count: got %0d expected 3", edge_total - e0);
        end
        vectors++;
        if (press_total - p0 !== 3) begin
            miscompares++;
            $display("FAIL chain_press_count: got %0d expected 3", press_total - p0);
        end
        vectors++;
        if (release_total - r0 !== 3) begin
            miscompares++;
            $display("FAIL chain_release_count: got %0d expected 3", release_total - r0);
        end
        vectors++;
        if (both_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL press_and_release_together: got %b expected 0", both_seen);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce_press();
        test_reset_mid_qualify();
        test_reset_while_pressed();
        test_back_to_back_downstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_boton_antirrebote
`default_nettype wire
